switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Conditions the 10 raw slide-switch pins before they reach the soc_system switch PIO input
//  (nios_switches_external_connection_export).
//  - Synchronises each bit into clk_clk.
//  - Filters contact bounce per bit with an independent stability counter.
//  - Emits one-cycle rise/fall pulses for each debounced transition.
//  - Optional sticky pending/IRQ logic lets software poll or take an interrupt on switch changes.
// PARAMETERS
//  WIDTH          10      number of switch bits
//  STABLE_CYCLES  500000  consecutive cycles a synced bit must differ from its output before
//                         the output updates (10 ms @ 50 MHz); legal range >= 1
//  CNT_W          $clog2(STABLE_CYCLES+1)  per-bit counter width (derived, do not override)
// PORTS
//  clk_clk        in   1      system clock, 50 MHz; same clock as soc_system
//  reset_reset    in   1      asynchronous, active-high reset
//  sw_raw         in   WIDTH  raw switch pins, asynchronous to clk_clk
//  sw_debounced   out  WIDTH  filtered level; drives nios_switches_external_connection_export
//  sw_rise        out  WIDTH  one-cycle pulse per bit on a debounced 0->1 transition
//  sw_fall        out  WIDTH  one-cycle pulse per bit on a debounced 1->0 transition
//  sw_irq         out  1      [SW_DEBOUNCE_IRQ_EN] OR of sw_pending
//  sw_pending     out  WIDTH  [SW_DEBOUNCE_IRQ_EN] sticky per-bit change flags
//  sw_irq_ack     in   1      [SW_DEBOUNCE_IRQ_EN] one-cycle clear of all pending flags
// BEHAVIOUR
//  Reset (async assert, synchronous release): the following are 0:
//   - both synchroniser flops and all counters
//   - sw_debounced, sw_rise, sw_fall
//   - sw_pending and sw_irq
//  Sync: 2-flop synchroniser per bit; sync = second flop output.
//  Per-bit FSM, all bits independent:
//   STABLE: sync==sw_debounced -> cnt=0, stay.
//           sync!=sw_debounced -> cnt=1, go to SETTLING.
//   SETTLING: sync==sw_debounced (bounce) -> cnt=0, go to STABLE, no output change.
//             sync!=sw_debounced and cnt==STABLE_CYCLES-1 -> flip sw_debounced to sync,
//             pulse sw_rise or sw_fall for exactly 1 cycle, cnt=0, go to STABLE.
//             Otherwise cnt++.
//  STABLE_CYCLES==1: the output flips on the first cycle sync differs; no SETTLING dwell.
//  Latency: clean raw edge -> sw_debounced change = 2 (sync) + STABLE_CYCLES clk_clk cycles.
//   The pulse is asserted in the same cycle sw_debounced changes.
//  Glitch rejection: any excursion shorter than STABLE_CYCLES synced cycles produces no output
//   change and no pulse.
//  Counter wrap: cnt never exceeds STABLE_CYCLES-1, so no wrap or saturation is possible.
//  Multiple bits may transition in the same cycle. sw_rise and sw_fall are never both set for
//   the same bit in the same cycle.
//  After reset release, a switch already high produces sw_debounced=1 and a sw_rise pulse
//   2+STABLE_CYCLES cycles later. This is intended.
//  Reset mid-operation: everything clears immediately and any settling count is discarded.
//  All outputs are registered.
// CONFIGURATION
//  SW_DEBOUNCE_IRQ_EN defined:
//   - sw_pending[i] is set on sw_rise[i]|sw_fall[i].
//   - sw_irq_ack clears all bits; a set in the same cycle as ack wins for that bit.
//   - sw_irq = |sw_pending, registered, so it asserts 1 cycle after the pulse.
//  SW_DEBOUNCE_IRQ_EN undefined:
//   - sw_irq, sw_pending and sw_irq_ack are absent from the port list.
//   - No pending logic is synthesised; the remaining behaviour is identical.
// TESTING (STABLE_CYCLES=8, WIDTH=10)
//  1 Reset held with sw_raw=0x3FF -> all outputs 0. Release -> sw_debounced=0x3FF exactly
//    10 cycles later and sw_rise=0x3FF for 1 cycle.
//  2 bit0 toggles every 3 cycles for 30 cycles, then holds 1 -> sw_debounced[0] rises exactly
//    10 cycles after the final edge, with a single sw_rise[0] pulse.
//  3 bit5 at 1 for 7 cycles then back to 0 -> sw_debounced, sw_rise and sw_fall stay 0.
//  4 From 0x001, set bit1 and clear bit0 in the same cycle -> 10 cycles later
//    sw_debounced=0x002 with sw_rise=0x002 and sw_fall=0x001 in the same cycle.
//  5 reset_reset asserted 5 cycles into a settle -> outputs 0 at once. After release,
//    the change takes a full 10 cycles.
//  6 [IRQ_EN] bit3 fall -> sw_pending=0x008 and sw_irq=1. sw_irq_ack pulsed in the same
//    cycle as a bit1 rise -> sw_pending=0x002 and sw_irq stays 1.

Source files
------------

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: 2-flop synchroniser, per-bit bounce filter and rise/fall pulses.
// Define SW_DEBOUNCE_IRQ_EN to add sticky per-bit pending flags and an interrupt output.
module switch_debouncer #(
  parameter  int WIDTH         = 10,
  parameter  int STABLE_CYCLES = 500000,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_debounced,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
`ifdef SW_DEBOUNCE_IRQ_EN
  ,
  output logic             sw_irq,
  output logic [WIDTH-1:0] sw_pending,
  input  logic             sw_irq_ack
`endif
);

  typedef enum logic {ST_STABLE, ST_SETTLING} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1, r_sync2;
  logic [WIDTH-1:0] r_debounced, r_rise, r_fall;
  logic [WIDTH-1:0] w_debounced_next, w_rise_next, w_fall_next;
  state_e           r_state      [WIDTH];
  state_e           w_state_next [WIDTH];
  logic [CNT_W-1:0] r_cnt        [WIDTH];
  logic [CNT_W-1:0] w_cnt_next   [WIDTH];

  // NOTE: non-blocking so r_sync2 takes the old r_sync1; blocking would merge both stages.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: the counters are plain flops and are reset, so a reset mid-settle discards any count.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_STABLE;
        r_cnt[i]   <= '0;
      end
      r_debounced <= '0;
      r_rise      <= '0;
      r_fall      <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= w_state_next[i];
        r_cnt[i]   <= w_cnt_next[i];
      end
      r_debounced <= w_debounced_next;
      r_rise      <= w_rise_next;
      r_fall      <= w_fall_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_debounced_next = r_debounced;
    w_rise_next      = '0;
    w_fall_next      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_state_next[i] = r_state[i];
      w_cnt_next[i]   = r_cnt[i];
      unique case (r_state[i])
        ST_STABLE: begin
          w_cnt_next[i] = '0;
          if (r_sync2[i] != r_debounced[i]) begin
            if (STABLE_CYCLES == 1) begin
              w_debounced_next[i] = r_sync2[i];
              w_rise_next[i]      = r_sync2[i];
              w_fall_next[i]      = ~r_sync2[i];
            end else begin
              w_cnt_next[i]   = CNT_W'(1);
              w_state_next[i] = ST_SETTLING;
            end
          end
        end
        ST_SETTLING: begin
          if (r_sync2[i] == r_debounced[i]) begin
            w_cnt_next[i]   = '0;
            w_state_next[i] = ST_STABLE;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_debounced_next[i] = r_sync2[i];
            w_rise_next[i]      = r_sync2[i];
            w_fall_next[i]      = ~r_sync2[i];
            w_cnt_next[i]       = '0;
            w_state_next[i]     = ST_STABLE;
          end else begin
            w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          w_cnt_next[i]   = '0;
          w_state_next[i] = ST_STABLE;
        end
      endcase
    end
  end

  assign sw_debounced = r_debounced;
  assign sw_rise      = r_rise;
  assign sw_fall      = r_fall;

`ifdef SW_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] r_pending, w_pending_next;
  logic             r_irq;

  // A pulse seen in the ack cycle survives the clear.
  always_comb begin
    w_pending_next = (sw_irq_ack ? '0 : r_pending) | r_rise | r_fall;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_irq     <= |w_pending_next;
    end
  end

  assign sw_pending = r_pending;
  assign sw_irq     = r_irq;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed timing scenarios plus random bouncing, checked
// against a sliding-window model (output flips once the last STABLE_CYCLES synced samples all differ).
module tb_switch_debouncer;
  localparam int W  = 10;
  localparam int SC = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic         ack;
  logic [W-1:0] sw_debounced, sw_rise, sw_fall;
`ifdef SW_DEBOUNCE_IRQ_EN
  logic [W-1:0] sw_pending;
  logic         sw_irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .sw_raw       (sw_raw),
    .sw_debounced (sw_debounced),
    .sw_rise      (sw_rise),
    .sw_fall      (sw_fall)
`ifdef SW_DEBOUNCE_IRQ_EN
    ,
    .sw_irq       (sw_irq),
    .sw_pending   (sw_pending),
    .sw_irq_ack   (ack)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model
  logic [W-1:0]  m_s1, m_s2, m_deb, m_rise, m_fall, m_pend;
  logic          m_irq;
  logic [SC-1:0] m_hist [W];

  always @(posedge clk or posedge rst) begin : model_blk
    logic [W-1:0]  n_pend, n_deb, n_rise, n_fall;
    logic [SC-1:0] n_hist [W];
    if (rst) begin
      m_s1 <= '0; m_s2 <= '0; m_deb <= '0; m_rise <= '0; m_fall <= '0;
      m_pend <= '0; m_irq <= 1'b0;
      for (int i = 0; i < W; i++) m_hist[i] <= '0;
    end else begin
      n_pend = (ack ? '0 : m_pend) | m_rise | m_fall;
      n_deb  = m_deb;
      n_rise = '0;
      n_fall = '0;
      for (int i = 0; i < W; i++) begin
        n_hist[i] = {m_hist[i][SC-2:0], m_s2[i]};
        if (n_hist[i] == {SC{~m_deb[i]}}) begin
          n_deb[i]  = m_s2[i];
          n_rise[i] = m_s2[i];
          n_fall[i] = ~m_s2[i];
        end
      end
      for (int i = 0; i < W; i++) m_hist[i] <= n_hist[i];
      m_deb <= n_deb; m_rise <= n_rise; m_fall <= n_fall;
      m_pend <= n_pend; m_irq <= |n_pend;
      m_s2 <= m_s1; m_s1 <= sw_raw;
    end
  end

`ifdef SW_DEBOUNCE_IRQ_EN
  wire [3*W+W:0] obs   = {sw_debounced, sw_rise, sw_fall, sw_pending, sw_irq};
  wire [3*W+W:0] exp_m = {m_deb, m_rise, m_fall, m_pend, m_irq};
`else
  wire [3*W-1:0] obs   = {sw_debounced, sw_rise, sw_fall};
  wire [3*W-1:0] exp_m = {m_deb, m_rise, m_fall};
`endif

  task automatic test_reset();
    logic [W-1:0] ed, er;
    rst = 1'b1; sw_raw = '1; ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== '0) $display("FAIL reset_hold: got %h expected 0", obs);
    else n_pass++;
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      ed = (c >= 10) ? 10'h3FF : 10'h000;
      er = (c == 10) ? 10'h3FF : 10'h000;
      n_checks++;
      if ({sw_debounced, sw_rise, sw_fall} !== {ed, er, 10'h000})
        $display("FAIL reset_release c=%0d: got deb=%h rise=%h fall=%h expected deb=%h rise=%h fall=000",
                 c, sw_debounced, sw_rise, sw_fall, ed, er);
      else n_pass++;
      n_checks++;
      if (obs !== exp_m) $display("FAIL model_reset c=%0d: got %h expected %h", c, obs, exp_m);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    sw_raw = '0;
    repeat (12) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_m) $display("FAIL model_clear: got %h expected %h", obs, exp_m);
      else n_pass++;
    end
    for (int t = 0; t < 10; t++) begin
      sw_raw[0] = ~t[0];
      repeat (3) begin
        @(negedge clk);
        n_checks++;
        if (sw_debounced[0] !== 1'b0 || sw_rise[0] !== 1'b0)
          $display("FAIL bounce_hold: got deb0=%b rise0=%b expected 0 0", sw_debounced[0], sw_rise[0]);
        else n_pass++;
      end
    end
    sw_raw[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      n_checks++;
      if (sw_debounced[0] !== (c >= 10) || sw_rise[0] !== (c == 10))
        $display("FAIL bounce_settle c=%0d: got deb0=%b rise0=%b expected %b %b",
                 c, sw_debounced[0], sw_rise[0], c >= 10, c == 10);
      else n_pass++;
      n_checks++;
      if (obs !== exp_m) $display("FAIL model_bounce c=%0d: got %h expected %h", c, obs, exp_m);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    sw_raw[5] = 1'b1;
    repeat (7) @(negedge clk);
    sw_raw[5] = 1'b0;
    repeat (15) begin
      @(negedge clk);
      n_checks++;
      if ({sw_debounced, sw_rise, sw_fall} !== {10'h001, 10'h000, 10'h000})
        $display("FAIL glitch: got deb=%h rise=%h fall=%h expected 001 000 000",
                 sw_debounced, sw_rise, sw_fall);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] ed, er, ef;
    sw_raw = 10'h002;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      ed = (c >= 10) ? 10'h002 : 10'h001;
      er = (c == 10) ? 10'h002 : 10'h000;
      ef = (c == 10) ? 10'h001 : 10'h000;
      n_checks++;
      if ({sw_debounced, sw_rise, sw_fall} !== {ed, er, ef})
        $display("FAIL simultaneous c=%0d: got deb=%h rise=%h fall=%h expected %h %h %h",
                 c, sw_debounced, sw_rise, sw_fall, ed, er, ef);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] ed, er;
    sw_raw = 10'h006;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== '0) $display("FAIL reset_mid_async: got %h expected 0", obs);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      ed = (c >= 10) ? 10'h006 : 10'h000;
      er = (c == 10) ? 10'h006 : 10'h000;
      n_checks++;
      if ({sw_debounced, sw_rise} !== {ed, er})
        $display("FAIL reset_mid_settle c=%0d: got deb=%h rise=%h expected %h %h",
                 c, sw_debounced, sw_rise, ed, er);
      else n_pass++;
    end
  endtask

`ifdef SW_DEBOUNCE_IRQ_EN
  task automatic test_irq();
    sw_raw = 10'h00C;
    repeat (12) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_checks++;
    if ({sw_pending, sw_irq} !== {10'h000, 1'b0})
      $display("FAIL irq_ack_clear: got pend=%h irq=%b expected 000 0", sw_pending, sw_irq);
    else n_pass++;
    sw_raw = 10'h004;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 11) begin
        n_checks++;
        if ({sw_pending, sw_irq} !== {10'h008, 1'b1})
          $display("FAIL irq_fall: got pend=%h irq=%b expected 008 1", sw_pending, sw_irq);
        else n_pass++;
      end
    end
    sw_raw = 10'h006;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      ack = 1'b0;
      if (c == 10) begin
        n_checks++;
        if (sw_rise !== 10'h002) $display("FAIL irq_rise_pulse: got rise=%h expected 002", sw_rise);
        else n_pass++;
        ack = 1'b1;
      end
      if (c == 11) begin
        n_checks++;
        if ({sw_pending, sw_irq} !== {10'h002, 1'b1})
          $display("FAIL irq_ack_vs_set: got pend=%h irq=%b expected 002 1", sw_pending, sw_irq);
        else n_pass++;
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 11) == 0) sw_raw[i] = ~sw_raw[i];
`ifdef SW_DEBOUNCE_IRQ_EN
      ack = ($urandom_range(0, 7) == 0);
`endif
      @(negedge clk);
      n_checks++;
      if (obs !== exp_m) $display("FAIL model_random c=%0d: got %h expected %h", c, obs, exp_m);
      else n_pass++;
    end
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw_raw = '0; ack = 1'b0;
    test_reset();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
`ifdef SW_DEBOUNCE_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
